// File: rtl/pg_rule_filter_pkg.sv
// Shared types and constants for the port-group rule filter stage.
// Entry and tag layouts are fixed here; the top's RULE_WIDTH must match PG_RULE_WIDTH.
package pg_rule_filter_pkg;

  localparam int PG_AWIDTH     = 8;
  localparam int PG_RULE_WIDTH = 16;
  localparam int PU_LATENCY    = 12;
  localparam int PG_FIFO_DEPTH = 32;

  typedef struct packed {
    logic [PG_RULE_WIDTH-1:0] rule;
    logic                     hit;
    logic                     last;
  } pg_filt_entry_t;

  // Rule id travelling alongside the port group while port_unit evaluates it
  typedef struct packed {
    logic                     valid;
    logic [PG_RULE_WIDTH-1:0] rule;
    logic                     last;
  } pg_filt_tag_t;

endpackage

// File: rtl/pg_filt_fifo.sv
// Show-ahead synchronous FIFO of filter entries with a registered occupancy count.
// Head entry is presented combinationally from the storage array and forced to zero when empty.
module pg_filt_fifo
  import pg_rule_filter_pkg::*;
#(
  parameter int DEPTH = PG_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  pg_filt_entry_t         din,
  input  logic                   pop,
  output pg_filt_entry_t         dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  pg_filt_entry_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic [AW:0]    count_next;
  logic           do_pop;

  assign valid      = (count_reg != '0);
  assign do_pop     = pop & valid;
  assign count_next = count_reg + (AW+1)'(push) - (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  assign dout  = valid ? mem[rd_ptr_reg] : '0;
  assign count = count_reg;

endmodule

// File: rtl/pg_rule_filter.sv
// Port-group match stage: issues candidate port groups to port_unit, re-aligns rule ids with
// the delayed port_match and queues surviving rules plus end-of-packet markers for the consumer.
module pg_rule_filter #(
  parameter int RULE_WIDTH = pg_rule_filter_pkg::PG_RULE_WIDTH,
  parameter int PU_LATENCY = pg_rule_filter_pkg::PU_LATENCY,
  parameter int FIFO_DEPTH = pg_rule_filter_pkg::PG_FIFO_DEPTH
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [RULE_WIDTH-1:0]                    in_rule,
  input  logic [pg_rule_filter_pkg::PG_AWIDTH-1:0] in_pg,
  input  logic                                     in_last,
  input  logic [15:0]                              in_src_port,
  input  logic [15:0]                              in_dst_port,
  input  logic                                     in_tcp,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  output logic [pg_rule_filter_pkg::PG_AWIDTH-1:0] pu_pg,
  output logic                                     pu_pg_valid,
  output logic [15:0]                              pu_src_port,
  output logic [15:0]                              pu_dst_port,
  output logic                                     pu_tcp,
  input  logic                                     pu_port_match,
  output logic [RULE_WIDTH-1:0]                    out_rule,
  output logic                                     out_hit,
  output logic                                     out_last,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [31:0]                              match_cnt,
  output logic [31:0]                              drop_cnt,
  output logic                                     align_err
);

  localparam int AWIDTH = pg_rule_filter_pkg::PG_AWIDTH;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  typedef pg_rule_filter_pkg::pg_filt_entry_t entry_t;
  typedef pg_rule_filter_pkg::pg_filt_tag_t   tag_t;

  logic [CW-1:0]     inflight_reg;
  logic [CW-1:0]     inflight_next;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       occupancy;
  logic              accept;
  logic              emerge;
  logic              push;
  logic              pop;
  tag_t              tail_tag;
  entry_t            push_entry;
  entry_t            head_entry;

  logic [AWIDTH-1:0] pu_pg_reg;
  logic              pu_pg_valid_reg;
  logic [15:0]       pu_src_port_reg;
  logic [15:0]       pu_dst_port_reg;
  logic              pu_tcp_reg;
  logic [31:0]       match_cnt_reg;
  logic [31:0]       drop_cnt_reg;
  logic              align_err_reg;

  // Each in-flight tag holds a FIFO slot, so a push can never find the FIFO full
  assign occupancy     = {1'b0, fifo_cnt} + {1'b0, inflight_reg};
  assign in_ready      = rst_n & (occupancy < (CW+1)'(FIFO_DEPTH));
  assign accept        = in_valid & in_ready;
  assign emerge        = tail_tag.valid;
  assign push          = emerge & (pu_port_match | tail_tag.last);
  assign pop           = out_valid & out_ready;
  assign inflight_next = inflight_reg + CW'(accept) - CW'(emerge);

  generate
    for (genvar gi = 0; gi <= PU_LATENCY; gi++) begin : g_tag
      tag_t stage_reg;
      tag_t stage_next;
      if (gi == 0) begin : g_head
        assign stage_next = '{valid: accept, rule: in_rule, last: in_last};
      end else begin : g_body
        assign stage_next = g_tag[gi-1].stage_reg;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= stage_next;
        end
      end
    end
  endgenerate

  assign tail_tag = g_tag[PU_LATENCY].stage_reg;

  // A miss on the last candidate still leaves an empty marker so the consumer sees end-of-packet
  always_comb begin
    push_entry      = '0;
    push_entry.hit  = pu_port_match;
    push_entry.last = tail_tag.last;
    if (pu_port_match) begin
      push_entry.rule = tail_tag.rule;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg    <= '0;
      pu_pg_reg       <= '0;
      pu_pg_valid_reg <= 1'b0;
      pu_src_port_reg <= '0;
      pu_dst_port_reg <= '0;
      pu_tcp_reg      <= 1'b0;
      match_cnt_reg   <= '0;
      drop_cnt_reg    <= '0;
      align_err_reg   <= 1'b0;
    end else begin
      inflight_reg    <= inflight_next;
      pu_pg_valid_reg <= accept;
      if (accept) begin
        pu_pg_reg       <= in_pg;
        pu_src_port_reg <= in_src_port;
        pu_dst_port_reg <= in_dst_port;
        pu_tcp_reg      <= in_tcp;
      end
      if (emerge && pu_port_match) begin
        match_cnt_reg <= match_cnt_reg + 32'd1;
      end
      if (emerge && !pu_port_match) begin
        drop_cnt_reg <= drop_cnt_reg + 32'd1;
      end
      if (pu_port_match && !emerge) begin
        align_err_reg <= 1'b1;
      end
    end
  end

  pg_filt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_entry),
    .valid (out_valid),
    .count (fifo_cnt)
  );

  assign pu_pg       = pu_pg_reg;
  assign pu_pg_valid = pu_pg_valid_reg;
  assign pu_src_port = pu_src_port_reg;
  assign pu_dst_port = pu_dst_port_reg;
  assign pu_tcp      = pu_tcp_reg;
  assign out_rule    = head_entry.rule;
  assign out_hit     = head_entry.hit;
  assign out_last    = head_entry.last;
  assign match_cnt   = match_cnt_reg;
  assign drop_cnt    = drop_cnt_reg;
  assign align_err   = align_err_reg;

endmodule

// File: tb/tb_pg_rule_filter.sv
// Bench for pg_rule_filter: emulates port_unit, keeps a queue-based expectation of the output
// stream, credits and counters, and checks the DUT against it every cycle.
module tb_pg_rule_filter;
  import pg_rule_filter_pkg::*;

  localparam int L     = 12;
  localparam int DEPTH = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [15:0]          in_rule = '0;
  logic [PG_AWIDTH-1:0] in_pg = '0;
  logic                 in_last = 1'b0;
  logic [15:0]          in_src_port = '0;
  logic [15:0]          in_dst_port = '0;
  logic                 in_tcp = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [PG_AWIDTH-1:0] pu_pg;
  logic                 pu_pg_valid;
  logic [15:0]          pu_src_port;
  logic [15:0]          pu_dst_port;
  logic                 pu_tcp;
  logic                 pu_port_match = 1'b0;
  logic [15:0]          out_rule;
  logic                 out_hit;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [31:0]          match_cnt;
  logic [31:0]          drop_cnt;
  logic                 align_err;

  pg_rule_filter dut (
    .clk (clk), .rst_n (rst_n),
    .in_rule (in_rule), .in_pg (in_pg), .in_last (in_last),
    .in_src_port (in_src_port), .in_dst_port (in_dst_port), .in_tcp (in_tcp),
    .in_valid (in_valid), .in_ready (in_ready),
    .pu_pg (pu_pg), .pu_pg_valid (pu_pg_valid), .pu_src_port (pu_src_port),
    .pu_dst_port (pu_dst_port), .pu_tcp (pu_tcp), .pu_port_match (pu_port_match),
    .out_rule (out_rule), .out_hit (out_hit), .out_last (out_last),
    .out_valid (out_valid), .out_ready (out_ready),
    .match_cnt (match_cnt), .drop_cnt (drop_cnt), .align_err (align_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Match rule used both by the port_unit emulation and by the expectation model
  logic [255:0] match_tbl = '0;
  function automatic logic pu_fn(input logic [7:0] pg, input logic [15:0] s,
                                 input logic [15:0] d, input logic t);
    return match_tbl[pg] ^ (^(s ^ d)) ^ t;
  endfunction

  // port_unit emulation: answers each issued port group L cycles later
  bit sched [int];
  bit inject = 1'b0;
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      sched.delete();
      pu_port_match = 1'b0;
    end else begin
      pu_port_match = inject | (sched.exists(cyc) ? sched[cyc] : 1'b0);
      if (sched.exists(cyc)) sched.delete(cyc);
      if (pu_pg_valid) sched[cyc + L] = pu_fn(pu_pg, pu_src_port, pu_dst_port, pu_tcp);
    end
  end

  // Expectation model
  typedef struct { int due; bit push; bit hit; } em_t;
  typedef struct { logic [15:0] rule; bit hit; bit last; } exp_t;
  em_t         em_q [$];
  exp_t        out_q [$];
  int          inflight_n = 0;
  int          fifo_n = 0;
  logic [31:0] exp_match = '0;
  logic [31:0] exp_drop = '0;
  bit          exp_align = 1'b0;
  bit          prev_acc = 1'b0;
  logic [7:0]  prev_pg;
  logic [15:0] prev_src, prev_dst;
  bit          prev_tcp;

  always @(negedge clk) begin : monitor
    bit   emerge_now, acc, popn, m;
    em_t  e;
    exp_t x;
    if (!rst_n) begin
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_rule", 32'(out_rule), 0);
      chk("rst_pu_pg_valid", 32'(pu_pg_valid), 0);
      chk("rst_match_cnt", match_cnt, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_align_err", 32'(align_err), 0);
      em_q.delete(); out_q.delete();
      inflight_n = 0; fifo_n = 0; exp_match = 0; exp_drop = 0; exp_align = 0; prev_acc = 0;
    end else begin
      emerge_now = (em_q.size() > 0) && (em_q[0].due == cyc);
      chk("in_ready", 32'(in_ready), 32'((inflight_n + fifo_n) < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(fifo_n > 0));
      if (out_valid && fifo_n > 0 && out_q.size() > 0) begin
        chk("out_rule", 32'(out_rule), 32'(out_q[0].rule));
        chk("out_hit", 32'(out_hit), 32'(out_q[0].hit));
        chk("out_last", 32'(out_last), 32'(out_q[0].last));
      end
      chk("match_cnt", match_cnt, exp_match);
      chk("drop_cnt", drop_cnt, exp_drop);
      chk("align_err", 32'(align_err), 32'(exp_align));
      chk("pu_pg_valid", 32'(pu_pg_valid), 32'(prev_acc));
      if (prev_acc) begin
        chk("pu_pg", 32'(pu_pg), 32'(prev_pg));
        chk("pu_src_port", 32'(pu_src_port), 32'(prev_src));
        chk("pu_dst_port", 32'(pu_dst_port), 32'(prev_dst));
        chk("pu_tcp", 32'(pu_tcp), 32'(prev_tcp));
      end
      chk("occupancy_bound", 32'((inflight_n + fifo_n) <= DEPTH), 1);

      acc  = in_valid && in_ready;
      popn = out_valid && out_ready && fifo_n > 0;
      prev_acc = acc;
      if (acc) begin
        m = pu_fn(in_pg, in_src_port, in_dst_port, in_tcp);
        e.due = cyc + 1 + L; e.push = m | in_last; e.hit = m;
        em_q.push_back(e);
        if (m || in_last) begin
          x.rule = m ? in_rule : 16'd0; x.hit = m; x.last = in_last;
          out_q.push_back(x);
        end
        inflight_n++;
        prev_pg = in_pg; prev_src = in_src_port; prev_dst = in_dst_port; prev_tcp = in_tcp;
      end
      if (emerge_now) begin
        e = em_q.pop_front();
        inflight_n--;
        if (e.push) fifo_n++;
        if (e.hit) exp_match++; else exp_drop++;
      end
      if (pu_port_match && !emerge_now) exp_align = 1'b1;
      if (popn) begin
        x = out_q.pop_front();
        fifo_n--;
        pops++;
        $display("pop %0d: rule=%0d hit=%0b last=%0b cycle=%0d", pops, out_rule, out_hit, out_last, cyc);
      end
    end
  end

  bit rand_mode = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 99) < 60);
  endtask

  task automatic send(input logic [15:0] r, input logic [7:0] pg, input bit last,
                      input logic [15:0] s, input logic [15:0] d, input bit t, output int acc_cyc);
    int w;
    w = 0;
    in_rule = r; in_pg = pg; in_last = last; in_src_port = s; in_dst_port = d; in_tcp = t;
    in_valid = 1'b1;
    while (!in_ready && w < 2000) begin
      tick();
      w++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 1);
    acc_cyc = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output int seen_cyc);
    int w;
    w = 0;
    while (!out_valid && w < budget) begin
      tick();
      w++;
    end
    if (!out_valid) chk("wait_out_timeout", 32'(out_valid), 1);
    seen_cyc = cyc;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t0, seen, hi, imm, pops0, w;
    logic [15:0] s, d;
    bit t;
    repeat (3) tick();
    chk("init_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    tick();

    // Single matching rule: visible exactly 14 cycles after accept
    match_tbl = '0; match_tbl[3] = 1'b1;
    send(16'd5, 8'd3, 1'b1, 16'd0, 16'd0, 1'b0, t0);
    wait_out(40, seen);
    chk("t1_latency", 32'(seen), 32'(t0 + 14));
    chk("t1_rule", 32'(out_rule), 5);
    chk("t1_hit", 32'(out_hit), 1);
    chk("t1_last", 32'(out_last), 1);
    pop_one();
    tick();
    chk("t1_match_cnt", match_cnt, 1);

    // Four rules, only rule 2 matches: hit entry then empty end marker
    match_tbl = '0; match_tbl[11] = 1'b1;
    for (int i = 0; i < 4; i++) send(16'(i + 1), 8'(10 + i), i == 3, 16'd0, 16'd0, 1'b0, t0);
    repeat (20) tick();
    chk("t2_rule_a", 32'(out_rule), 2);
    chk("t2_hit_a", 32'(out_hit), 1);
    chk("t2_last_a", 32'(out_last), 0);
    pop_one();
    chk("t2_rule_b", 32'(out_rule), 0);
    chk("t2_hit_b", 32'(out_hit), 0);
    chk("t2_last_b", 32'(out_last), 1);
    pop_one();
    tick();
    chk("t2_drop_cnt", drop_cnt, 3);
    chk("t2_match_cnt", match_cnt, 2);

    // Back-pressure: exactly 32 accepts, then stall, then all 40 drain in order
    match_tbl = '0; match_tbl[20] = 1'b1;
    pops0 = pops;
    imm = 0;
    for (int i = 0; i < 32; i++) begin
      if (in_ready) imm++;
      send(16'(100 + i), 8'd20, 1'b0, 16'd0, 16'd0, 1'b0, t0);
    end
    chk("t3_immediate_accepts", 32'(imm), 32);
    in_rule = 16'd132; in_pg = 8'd20; in_last = 1'b0; in_valid = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) hi++;
      tick();
    end
    chk("t3_stall_ready", 32'(hi), 0);
    out_ready = 1'b1;
    for (int i = 32; i < 40; i++) send(16'(100 + i), 8'd20, i == 39, 16'd0, 16'd0, 1'b0, t0);
    w = 0;
    while ((out_q.size() > 0 || em_q.size() > 0) && w < 300) begin tick(); w++; end
    chk("t3_pop_total", 32'(pops - pops0), 40);
    out_ready = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 8; i++) match_tbl[i*32 +: 32] = $urandom;
    rand_mode = 1'b1;
    s = 16'($urandom); d = 16'($urandom); t = 1'($urandom);
    for (int i = 0; i < 10000; i++) begin
      bit last;
      if ($urandom_range(0, 9) < 3) tick();
      last = ($urandom_range(0, 3) == 0);
      send(16'($urandom), 8'($urandom), last, s, d, t, t0);
      if (last) begin s = 16'($urandom); d = 16'($urandom); t = 1'($urandom); end
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while ((out_q.size() > 0 || em_q.size() > 0) && w < 500) begin tick(); w++; end
    chk("t4_drained", 32'(out_q.size() + em_q.size()), 0);
    out_ready = 1'b0;

    // Reset with entries queued and 6 tags in flight
    match_tbl[3] = 1'b1;
    send(16'd7, 8'd3, 1'b0, 16'd0, 16'd0, 1'b0, t0);
    send(16'd8, 8'd3, 1'b1, 16'd0, 16'd0, 1'b0, t0);
    repeat (16) tick();
    for (int i = 0; i < 6; i++) send(16'(200 + i), 8'd3, i == 5, 16'd0, 16'd0, 1'b0, t0);
    tick();
    chk("t5_pre_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", 32'(out_valid), 0);
    chk("t5_rst_match_cnt", match_cnt, 0);
    chk("t5_rst_in_ready", 32'(in_ready), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("t5_post_in_ready", 32'(in_ready), 1);
    tick();
    send(16'd9, 8'd3, 1'b1, 16'd0, 16'd0, 1'b0, t0);
    wait_out(40, seen);
    chk("t5_latency", 32'(seen), 32'(t0 + 14));
    chk("t5_rule", 32'(out_rule), 9);
    pop_one();
    repeat (20) tick();
    chk("t5_match_cnt", match_cnt, 1);
    chk("t5_align_clear", 32'(align_err), 0);

    // Stray port_match with no tag in the pipe
    inject = 1'b1;
    tick();
    inject = 1'b0;
    tick();
    chk("t6_align_err", 32'(align_err), 1);
    repeat (5) tick();
    chk("t6_align_sticky", 32'(align_err), 1);
    chk("t6_no_push", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
